// File: rtl/branch_resolve_unit.sv
// Branch resolution at the EX/MEM boundary: evaluates RV32I branch conditions in EX,
// holds the result in a MEM entry and drives predictor update, redirect, flush and perf counters.
module branch_resolve_unit #(
  parameter int XLEN      = 32,
  parameter int PHT_IDX_W = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ex_valid,
  input  logic                 ex_branch,
  input  logic [2:0]           ex_funct3,
  input  logic [XLEN-1:0]      ex_rs1,
  input  logic [XLEN-1:0]      ex_rs2,
  input  logic [XLEN-1:0]      ex_pc,
  input  logic [XLEN-1:0]      ex_imm,
  input  logic                 ex_pred_taken,
  input  logic [PHT_IDX_W-1:0] ex_pht_index,
  input  logic                 stall,
  output logic                 branch_resolved,
  output logic                 actual_taken,
  output logic [PHT_IDX_W-1:0] pht_indexMEM,
  output logic                 mispredict,
  output logic [XLEN-1:0]      PC_redirect,
  output logic [1:0]           flush,
  output logic [31:0]          branch_count,
  output logic [31:0]          mispredict_count
);

  typedef enum logic [2:0] {
    F3_BEQ  = 3'b000,
    F3_BNE  = 3'b001,
    F3_BLT  = 3'b100,
    F3_BGE  = 3'b101,
    F3_BLTU = 3'b110,
    F3_BGEU = 3'b111
  } funct3_e;

  logic            ex_taken;
  logic [XLEN-1:0] ex_target;
  logic [XLEN-1:0] ex_fallthrough;

  logic                 mem_valid;
  logic                 mem_done;
  logic                 kill_pending;
  logic                 mem_taken;
  logic                 mem_pred;
  logic [PHT_IDX_W-1:0] mem_pht_index;
  logic [XLEN-1:0]      mem_target;
  logic [XLEN-1:0]      mem_fallthrough;

  logic fire;
  logic mis;
  logic kill;

  // Reserved funct3 encodings (010/011) fall to the default and resolve not-taken.
  always_comb begin
    ex_taken = 1'b0;
    case (ex_funct3)
      F3_BEQ:  ex_taken = (ex_rs1 == ex_rs2);
      F3_BNE:  ex_taken = (ex_rs1 != ex_rs2);
      F3_BLT:  ex_taken = ($signed(ex_rs1) <  $signed(ex_rs2));
      F3_BGE:  ex_taken = ($signed(ex_rs1) >= $signed(ex_rs2));
      F3_BLTU: ex_taken = (ex_rs1 <  ex_rs2);
      F3_BGEU: ex_taken = (ex_rs1 >= ex_rs2);
      default: ex_taken = 1'b0;
    endcase
  end

  assign ex_target      = ex_pc + ex_imm;
  assign ex_fallthrough = ex_pc + XLEN'(4);

  assign fire = mem_valid & ~mem_done;
  assign mis  = fire & (mem_taken != mem_pred);
  assign kill = mis | kill_pending;

  assign branch_resolved = fire;
  assign actual_taken    = fire & mem_taken;
  assign pht_indexMEM    = fire ? mem_pht_index : '0;
  assign mispredict      = mis;
  assign PC_redirect     = mis ? (mem_taken ? mem_target : mem_fallthrough) : '0;
  assign flush           = mis ? 2'b10 : 2'b00;

  // A held entry resolves once (done), and a mispredict seen under stall must
  // still squash whatever younger branch is sitting in EX when the stall lifts.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_valid        <= 1'b0;
      mem_done         <= 1'b0;
      kill_pending     <= 1'b0;
      mem_taken        <= 1'b0;
      mem_pred         <= 1'b0;
      mem_pht_index    <= '0;
      mem_target       <= '0;
      mem_fallthrough  <= '0;
      branch_count     <= '0;
      mispredict_count <= '0;
    end else begin
      if (fire && (branch_count != 32'hFFFF_FFFF))
        branch_count <= branch_count + 32'd1;
      if (mis && (mispredict_count != 32'hFFFF_FFFF))
        mispredict_count <= mispredict_count + 32'd1;

      if (stall) begin
        if (fire)
          mem_done <= 1'b1;
        if (mis)
          kill_pending <= 1'b1;
      end else begin
        mem_valid       <= ex_valid & ex_branch & ~kill;
        mem_done        <= 1'b0;
        kill_pending    <= 1'b0;
        mem_taken       <= ex_taken;
        mem_pred        <= ex_pred_taken;
        mem_pht_index   <= ex_pht_index;
        mem_target      <= ex_target;
        mem_fallthrough <= ex_fallthrough;
      end
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: vector table, directed multi-cycle
// sequences and random traffic against a cycle-level reference model.
module tb_branch_resolve_unit;

  localparam int XLEN = 32;
  localparam int IW   = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic            ex_valid;
  logic            ex_branch;
  logic [2:0]      ex_funct3;
  logic [XLEN-1:0] ex_rs1;
  logic [XLEN-1:0] ex_rs2;
  logic [XLEN-1:0] ex_pc;
  logic [XLEN-1:0] ex_imm;
  logic            ex_pred_taken;
  logic [IW-1:0]   ex_pht_index;
  logic            stall;
  logic            branch_resolved;
  logic            actual_taken;
  logic [IW-1:0]   pht_indexMEM;
  logic            mispredict;
  logic [XLEN-1:0] PC_redirect;
  logic [1:0]      flush;
  logic [31:0]     branch_count;
  logic [31:0]     mispredict_count;

  always #5 clk = ~clk;

  branch_resolve_unit #(.XLEN(XLEN), .PHT_IDX_W(IW)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_branch(ex_branch),
    .ex_funct3(ex_funct3), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_pc(ex_pc),
    .ex_imm(ex_imm), .ex_pred_taken(ex_pred_taken), .ex_pht_index(ex_pht_index),
    .stall(stall), .branch_resolved(branch_resolved), .actual_taken(actual_taken),
    .pht_indexMEM(pht_indexMEM), .mispredict(mispredict), .PC_redirect(PC_redirect),
    .flush(flush), .branch_count(branch_count), .mispredict_count(mispredict_count)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: the branch waiting in MEM, whether it has already reported,
  // and whether a mispredict is still owed a squash of the next EX branch.
  logic          m_valid, m_fired, m_killp, m_taken, m_pred;
  logic [IW-1:0] m_idx;
  logic [31:0]   m_target, m_fall, m_bc, m_mc;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] rs1, rs2, pc, imm;
    logic        pred;
    logic [2:0]  idx;
    logic        exp_taken;
    logic        exp_mis;
    logic [31:0] exp_redirect;
  } vec_t;

  vec_t vecs[9];

  function automatic logic refTaken(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint sa = longint'(signed'(a));
    longint sb = longint'(signed'(b));
    longint ua = longint'(a);
    longint ub = longint'(b);
    case (f3)
      3'b000:  return ua == ub;
      3'b001:  return ua != ub;
      3'b100:  return sa <  sb;
      3'b101:  return sa >= sb;
      3'b110:  return ua <  ub;
      3'b111:  return ua >= ub;
      default: return 1'b0;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkModel();
    logic fire = m_valid && !m_fired;
    logic mis  = fire && (m_taken != m_pred);
    checkOutput("model.branch_resolved", 32'(branch_resolved), 32'(fire));
    checkOutput("model.actual_taken", 32'(actual_taken), 32'(fire && m_taken));
    checkOutput("model.pht_indexMEM", 32'(pht_indexMEM), fire ? 32'(m_idx) : 32'd0);
    checkOutput("model.mispredict", 32'(mispredict), 32'(mis));
    checkOutput("model.PC_redirect", PC_redirect, mis ? (m_taken ? m_target : m_fall) : 32'd0);
    checkOutput("model.flush", 32'(flush), mis ? 32'd2 : 32'd0);
    checkOutput("model.branch_count", branch_count, m_bc);
    checkOutput("model.mispredict_count", mispredict_count, m_mc);
  endtask

  task automatic modelEdge();
    logic fire = m_valid && !m_fired;
    logic mis  = fire && (m_taken != m_pred);
    if (rst) begin
      {m_valid, m_fired, m_killp, m_taken, m_pred} = '0;
      m_idx = '0; m_target = '0; m_fall = '0; m_bc = '0; m_mc = '0;
    end else begin
      if (fire && m_bc != 32'hFFFF_FFFF) m_bc = m_bc + 1;
      if (mis && m_mc != 32'hFFFF_FFFF) m_mc = m_mc + 1;
      if (stall) begin
        if (fire) m_fired = 1'b1;
        if (mis) m_killp = 1'b1;
      end else begin
        m_valid  = ex_valid && ex_branch && !mis && !m_killp;
        m_fired  = 1'b0;
        m_killp  = 1'b0;
        m_taken  = refTaken(ex_funct3, ex_rs1, ex_rs2);
        m_pred   = ex_pred_taken;
        m_idx    = ex_pht_index;
        m_target = ex_pc + ex_imm;
        m_fall   = ex_pc + 32'd4;
      end
    end
  endtask

  // Drive one cycle of inputs, clock it, then compare against the model on the falling edge.
  task automatic applyStimulus(input logic v, input logic br, input logic [2:0] f3,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] pc, input logic [31:0] imm,
                               input logic pred, input logic [2:0] idx,
                               input logic st, input logic r);
    ex_valid = v; ex_branch = br; ex_funct3 = f3; ex_rs1 = a; ex_rs2 = b;
    ex_pc = pc; ex_imm = imm; ex_pred_taken = pred; ex_pht_index = idx;
    stall = st; rst = r;
    @(posedge clk);
    modelEdge();
    @(negedge clk);
    checkModel();
  endtask

  task automatic idle(input logic st, input logic r);
    applyStimulus(1'b0, 1'b0, 3'b000, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 3'd0, st, r);
  endtask

  initial begin
    logic [31:0] bc0;
    logic [2:0]  f3s [8];
    f3s = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b110, 3'b111, 3'b010, 3'b011};

    vecs[0] = '{3'b000, 32'd5, 32'd5, 32'h100, 32'h20, 1'b0, 3'd3, 1'b1, 1'b1, 32'h120};
    vecs[1] = '{3'b100, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h40, 1'b1, 3'd1, 1'b1, 1'b0, 32'h0};
    vecs[2] = '{3'b110, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h40, 1'b1, 3'd2, 1'b0, 1'b1, 32'h204};
    vecs[3] = '{3'b001, 32'd7, 32'd7, 32'h240, 32'h10, 1'b0, 3'd0, 1'b0, 1'b0, 32'h0};
    vecs[4] = '{3'b101, 32'd1, 32'hFFFF_FFFF, 32'h300, 32'hFFFF_FFF0, 1'b0, 3'd5, 1'b1, 1'b1, 32'h2F0};
    vecs[5] = '{3'b111, 32'd1, 32'hFFFF_FFFF, 32'h400, 32'h8, 1'b1, 3'd6, 1'b0, 1'b1, 32'h404};
    vecs[6] = '{3'b010, 32'd9, 32'd9, 32'h500, 32'h8, 1'b1, 3'd7, 1'b0, 1'b1, 32'h504};
    vecs[7] = '{3'b000, 32'd1, 32'd2, 32'hFFFF_FFFC, 32'h8, 1'b1, 3'd4, 1'b0, 1'b1, 32'h0};
    vecs[8] = '{3'b110, 32'd1, 32'd2, 32'h600, 32'h80, 1'b1, 3'd2, 1'b1, 1'b0, 32'h0};

    {m_valid, m_fired, m_killp, m_taken, m_pred} = '0;
    m_idx = '0; m_target = '0; m_fall = '0; m_bc = '0; m_mc = '0;

    @(negedge clk);
    idle(1'b0, 1'b1);
    idle(1'b0, 1'b1);
    checkOutput("reset.branch_resolved", 32'(branch_resolved), 32'd0);
    checkOutput("reset.flush", 32'(flush), 32'd0);
    checkOutput("reset.branch_count", branch_count, 32'd0);
    checkOutput("reset.mispredict_count", mispredict_count, 32'd0);

    $display("[TB] back-to-back correct predictions");
    applyStimulus(1'b1, 1'b1, 3'b001, 32'd1, 32'd2, 32'h80, 32'h10, 1'b1, 3'd1, 1'b0, 1'b0);
    checkOutput("b2b.first_resolved", 32'(branch_resolved), 32'd1);
    checkOutput("b2b.first_index", 32'(pht_indexMEM), 32'd1);
    applyStimulus(1'b1, 1'b1, 3'b110, 32'd1, 32'd2, 32'h84, 32'h10, 1'b1, 3'd6, 1'b0, 1'b0);
    checkOutput("b2b.second_resolved", 32'(branch_resolved), 32'd1);
    checkOutput("b2b.second_index", 32'(pht_indexMEM), 32'd6);
    checkOutput("b2b.no_mispredict", 32'(mispredict), 32'd0);
    idle(1'b0, 1'b0);
    checkOutput("b2b.mispredict_count", mispredict_count, 32'd0);
    checkOutput("b2b.branch_count", branch_count, 32'd2);

    $display("[TB] vector table");
    for (int i = 0; i < 9; i++) begin
      applyStimulus(1'b1, 1'b1, vecs[i].f3, vecs[i].rs1, vecs[i].rs2, vecs[i].pc,
                    vecs[i].imm, vecs[i].pred, vecs[i].idx, 1'b0, 1'b0);
      checkOutput($sformatf("vec%0d.branch_resolved", i), 32'(branch_resolved), 32'd1);
      checkOutput($sformatf("vec%0d.actual_taken", i), 32'(actual_taken), 32'(vecs[i].exp_taken));
      checkOutput($sformatf("vec%0d.pht_indexMEM", i), 32'(pht_indexMEM), 32'(vecs[i].idx));
      checkOutput($sformatf("vec%0d.mispredict", i), 32'(mispredict), 32'(vecs[i].exp_mis));
      checkOutput($sformatf("vec%0d.PC_redirect", i), PC_redirect, vecs[i].exp_redirect);
      checkOutput($sformatf("vec%0d.flush", i), 32'(flush), vecs[i].exp_mis ? 32'd2 : 32'd0);
      idle(1'b0, 1'b0);
    end

    $display("[TB] mispredict resolving under a 3-cycle stall");
    bc0 = branch_count;
    applyStimulus(1'b1, 1'b1, 3'b000, 32'd5, 32'd5, 32'h700, 32'h20, 1'b0, 3'd2, 1'b0, 1'b0);
    checkOutput("stall.resolve_pulse", 32'(branch_resolved), 32'd1);
    checkOutput("stall.mispredict_pulse", 32'(mispredict), 32'd1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b1, 3'b000, 32'd1, 32'd1, 32'h704, 32'h40, 1'b0, 3'd5, 1'b1, 1'b0);
      checkOutput($sformatf("stall.no_repulse%0d", i), 32'(branch_resolved), 32'd0);
      checkOutput($sformatf("stall.no_remispredict%0d", i), 32'(mispredict), 32'd0);
    end
    applyStimulus(1'b1, 1'b1, 3'b000, 32'd1, 32'd1, 32'h704, 32'h40, 1'b0, 3'd5, 1'b0, 1'b0);
    checkOutput("stall.younger_killed", 32'(branch_resolved), 32'd0);
    idle(1'b0, 1'b0);
    checkOutput("stall.after_release", 32'(branch_resolved), 32'd0);
    checkOutput("stall.branch_count_once", branch_count, bc0 + 32'd1);

    $display("[TB] branch counter saturation");
    force dut.branch_count = 32'hFFFF_FFFF;
    #1;
    release dut.branch_count;
    m_bc = 32'hFFFF_FFFF;
    idle(1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 3'b001, 32'd3, 32'd4, 32'h800, 32'h10, 1'b1, 3'd3, 1'b0, 1'b0);
    checkOutput("sat.resolved", 32'(branch_resolved), 32'd1);
    idle(1'b0, 1'b0);
    checkOutput("sat.branch_count", branch_count, 32'hFFFF_FFFF);

    $display("[TB] reset while a stalled entry is valid");
    applyStimulus(1'b1, 1'b1, 3'b000, 32'd5, 32'd5, 32'h900, 32'h20, 1'b0, 3'd4, 1'b0, 1'b0);
    checkOutput("rststall.pending_pulse", 32'(branch_resolved), 32'd1);
    idle(1'b1, 1'b1);
    checkOutput("rststall.branch_resolved", 32'(branch_resolved), 32'd0);
    checkOutput("rststall.mispredict", 32'(mispredict), 32'd0);
    checkOutput("rststall.PC_redirect", PC_redirect, 32'd0);
    checkOutput("rststall.flush", 32'(flush), 32'd0);
    checkOutput("rststall.branch_count", branch_count, 32'd0);
    checkOutput("rststall.mispredict_count", mispredict_count, 32'd0);
    idle(1'b1, 1'b0);
    checkOutput("rststall.no_pulse_stalled", 32'(branch_resolved), 32'd0);
    idle(1'b0, 1'b0);
    checkOutput("rststall.no_pulse_released", 32'(branch_resolved), 32'd0);

    $display("[TB] random traffic");
    for (int i = 0; i < 600; i++) begin
      logic [31:0] a = $urandom;
      logic [31:0] b = ($urandom_range(0, 2) == 0) ? a : $urandom;
      logic [31:0] pc = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
      applyStimulus(1'($urandom_range(0, 4) != 0), 1'($urandom_range(0, 3) != 0),
                    f3s[$urandom_range(0, 7)], a, b, pc, $urandom,
                    1'($urandom), 3'($urandom), 1'($urandom_range(0, 3) == 0),
                    1'($urandom_range(0, 63) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Resolves conditional branches at the EX/MEM boundary, the counterpart to the ID-stage gshare predictor.
- Evaluates the RV32I branch condition in EX and registers the result into a MEM-stage entry.
- From that entry it drives the predictor update (branch_resolved, actual_taken, pht_indexMEM).
- On misprediction it drives the corrective redirect and flush.
- Keeps saturating branch and mispredict performance counters.

Parameters:
- XLEN, 32, datapath and PC width.
- PHT_IDX_W, 3, width of the predictor index carried with each branch.

Ports:
- clk  in  1  clock, all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- ex_valid  in  1  EX stage holds a live instruction.
- ex_branch  in  1  the EX instruction is a conditional branch.
- ex_funct3  in  3  branch type: 000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU.
- ex_rs1  in  XLEN  forwarded operand 1.
- ex_rs2  in  XLEN  forwarded operand 2.
- ex_pc  in  XLEN  PC of the branch.
- ex_imm  in  XLEN  sign-extended B-immediate.
- ex_pred_taken  in  1  prediction made in ID, carried down the pipeline.
- ex_pht_index  in  PHT_IDX_W  PHT index used at prediction time.
- stall  in  1  MEM stage frozen; the MEM entry holds.
- branch_resolved  out  1  one-cycle pulse; predictor update strobe.
- actual_taken  out  1  resolved direction (valid with branch_resolved).
- pht_indexMEM  out  PHT_IDX_W  index to update (valid with branch_resolved).
- mispredict  out  1  one-cycle pulse when actual_taken != predicted.
- PC_redirect  out  XLEN  corrected fetch PC; 0 when mispredict=0.
- flush  out  2  2'b10 on mispredict (squash IF/ID/EX), else 2'b00.
- branch_count  out  32  resolved branches, saturating.
- mispredict_count  out  32  mispredicts, saturating.

Behaviour:
- Reset:
  - All outputs are 0; flush=2'b00.
  - MEM entry invalid; done=0; kill_pending=0; both counters 0.
  - Reset mid-stall or mid-pending-kill discards everything.
- EX compare (combinational):
  - BLT/BGE compare signed; BLTU/BGEU compare unsigned; BEQ/BNE compare equality.
  - funct3 010/011 resolve as not-taken.
  - target = ex_pc + ex_imm, modulo 2^XLEN.
  - fallthrough = ex_pc + 4, wraps.
- MEM entry capture (rising edge, stall=0):
  - Registers {taken, pred, pht_index, target, fallthrough}.
  - mem_valid <= ex_valid & ex_branch & ~kill; done <= 0.
  - kill = mispredict (this cycle) | kill_pending. The EX instruction is younger than a mispredicted branch and must never resolve.
  - Non-branch or invalid EX: mem_valid <= 0.
- stall=1: entry, mem_valid and counters-of-record hold.
- Resolution:
  - fire = mem_valid & ~done.
  - branch_resolved = fire; actual_taken = fire & taken; pht_indexMEM = fire ? pht_index : 0.
  - mispredict = fire & (taken != pred).
  - On mispredict: PC_redirect = taken ? target : fallthrough; flush = 2'b10.
- Exactly-once rule:
  - When fire=1 and stall=1, set done <= 1, so a held entry never re-pulses or double-updates the PHT.
  - done clears on the next capture.
- Kill tracking:
  - If mispredict fires while stall=1, set kill_pending <= 1.
  - The next capture (stall=0) forces mem_valid <= 0 and clears kill_pending.
  - If mispredict fires with stall=0, kill applies directly and kill_pending stays 0.
- Latency: a branch in EX at cycle N with stall=0 produces its resolution pulses combinationally in cycle N+1.
- Counters:
  - On fire, branch_count increments.
  - On mispredict, mispredict_count also increments.
  - Each counter holds at 32'hFFFFFFFF.
- Correct predictions: no redirect, no flush; resolve pulse only.

Test Plan:
- BEQ rs1=rs2=5, pc=0x100, imm=0x20, pred=0, idx=3 → next cycle: branch_resolved=1, actual_taken=1, pht_indexMEM=3, mispredict=1, PC_redirect=0x120, flush=2'b10; counters 1/1.
- BLT rs1=0xFFFFFFFF, rs2=1, pred=1 → taken, no mispredict, flush=00. Repeat as BLTU → not taken, mispredict=1, PC_redirect=pc+4.
- Mispredicting branch resolves while stall=1 held 3 cycles → branch_resolved and mispredict pulse once only; branch_count=1. The younger EX branch present at release never resolves (no pulse on the following cycle).
- Back-to-back correctly predicted branches in EX on consecutive cycles, stall=0 → two consecutive single-cycle resolve pulses with correct indices; mispredict_count=0.
- pc=0xFFFFFFFC, not-taken, pred=1 → PC_redirect=0x00000000 (wrap). Separately, force branch_count=0xFFFFFFFF, then resolve → counter stays 0xFFFFFFFF.
- Assert rst while a MEM entry is valid and stall=1 → next cycle all outputs 0, counters 0, no resolve pulse after rst drops.
